// File: rtl/cdc_pkg.sv
// Shared types for the CDC transmit controller: FSM states and err bit positions.
package cdc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam int ERR_TO   = 0;
    localparam int ERR_SPUR = 1;

endpackage

// File: rtl/cdc_tx_ctrl_if.sv
// Source-side handshake plus the two-phase request/acknowledge crossing bundle.
interface cdc_tx_ctrl_if #(
    parameter int DW = 8
);

    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          x_req;
    logic [DW-1:0] x_data;
    logic          x_ack;

    // master: the controller; slave: upstream producer plus destination domain
    modport master (
        input  s_valid, s_data, x_ack,
        output s_ready, x_req, x_data
    );

    modport slave (
        output s_valid, s_data, x_ack,
        input  s_ready, x_req, x_data
    );

endinterface

// File: rtl/async_ff.sv
// Single register stage with asynchronous active-low clear; chained for synchronisers.
module async_ff #(
    parameter int DW = 1
) (
    input  logic          CP,
    input  logic          CLR,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    logic [DW-1:0] q_q;

    always_ff @(posedge CP or negedge CLR) begin
        if (!CLR) q_q <= '0;
        else      q_q <= d_i;
    end

    assign q_o = q_q;

endmodule

// File: rtl/cdc_tx_ctrl.sv
// Two-phase (toggle) request/acknowledge transmit controller for one word across a clock boundary.
module cdc_tx_ctrl
    import cdc_pkg::*;
#(
    parameter int DW     = 8,
    parameter int SYNC   = 2,
    parameter int TO_CYC = 256
) (
    input  logic                 CP,
    input  logic                 CLR,
    cdc_tx_ctrl_if.master        bus,
    input  logic                 err_clr,
    output logic [1:0]           err,
    output logic [15:0]          xfer_cnt
);

    localparam int             CW      = $clog2(TO_CYC);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TO_CYC - 1);
    localparam logic [CW-1:0]  CNT_PRE = CW'(TO_CYC - 2);

    state_e         state_q, state_d;
    logic           x_req_q, x_req_d;
    logic [DW-1:0]  x_data_q, x_data_d;
    logic [CW-1:0]  count_q, count_d;
    logic [1:0]     err_q, err_d, err_set;
    logic [15:0]    xfer_q, xfer_d;
    logic [SYNC:0]  ack_chain;
    logic           ack_s, ack_det, accept, s_ready;

    assign ack_chain[0] = bus.x_ack;

    for (genvar g = 0; g < SYNC; g++) begin : g_sync
        async_ff #(.DW(1)) u_ff (
            .CP  (CP),
            .CLR (CLR),
            .d_i (ack_chain[g]),
            .q_o (ack_chain[g+1])
        );
    end

    assign ack_s   = ack_chain[SYNC];
    assign ack_det = (ack_s == x_req_q);
    assign accept  = bus.s_valid && s_ready;

    always_ff @(posedge CP or negedge CLR) begin
        if (!CLR) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)  state_d = WAIT;
            WAIT:    if (ack_det) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state_q == IDLE);
    end

    // In WAIT an acknowledge takes priority over the timeout count reaching its limit.
    always_comb begin
        x_req_d  = x_req_q;
        x_data_d = x_data_q;
        count_d  = count_q;
        xfer_d   = xfer_q;
        err_set  = '0;
        if (state_q == IDLE) begin
            if (!ack_det) err_set[ERR_SPUR] = 1'b1;
            if (accept) begin
                x_req_d  = ~x_req_q;
                x_data_d = bus.s_data;
                count_d  = '0;
            end
        end else if (ack_det) begin
            xfer_d = xfer_q + 16'd1;
        end else if (count_q != CNT_MAX) begin
            count_d = count_q + CW'(1);
            if (count_q == CNT_PRE) err_set[ERR_TO] = 1'b1;
        end
        err_d = (err_q & ~{2{err_clr}}) | err_set;
    end

    always_ff @(posedge CP or negedge CLR) begin
        if (!CLR) begin
            x_req_q  <= 1'b0;
            x_data_q <= '0;
            count_q  <= '0;
            err_q    <= '0;
            xfer_q   <= '0;
        end else begin
            x_req_q  <= x_req_d;
            x_data_q <= x_data_d;
            count_q  <= count_d;
            err_q    <= err_d;
            xfer_q   <= xfer_d;
        end
    end

    assign bus.s_ready  = s_ready;
    assign bus.x_req    = x_req_q;
    assign bus.x_data   = x_data_q;
    assign err          = err_q;
    assign xfer_cnt     = xfer_q;

endmodule

// File: tb/tb_cdc_tx_ctrl.sv
// Self-checking bench for cdc_tx_ctrl: scoreboard of accepted words checked at each x_req toggle.
module tb_cdc_tx_ctrl;
    import cdc_pkg::*;

    localparam int DW     = 8;
    localparam int SYNC   = 2;
    localparam int TO_CYC = 256;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        err_clr;
    logic [1:0]  err;
    logic [15:0] xfer_cnt;

    always #5 clk = ~clk;

    cdc_tx_ctrl_if #(.DW(DW)) bus ();

    cdc_tx_ctrl #(.DW(DW), .SYNC(SYNC), .TO_CYC(TO_CYC)) dut (
        .CP       (clk),
        .CLR      (rst_n),
        .bus      (bus.master),
        .err_clr  (err_clr),
        .err      (err),
        .xfer_cnt (xfer_cnt)
    );

    int             pass_cnt = 0;
    int             total_cnt = 0;
    logic [DW-1:0]  exp_q[$];
    logic           exp_req = 1'b0;
    logic [15:0]    exp_cnt = 16'd0;

    task automatic test_reset();
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.x_ack   = 1'b0;
        err_clr     = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (bus.s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b want 1", bus.s_ready); else pass_cnt++;
        total_cnt++; if (bus.x_req !== 1'b0) $display("FAIL reset_x_req: got %b want 0", bus.x_req); else pass_cnt++;
        total_cnt++; if (bus.x_data !== 8'h00) $display("FAIL reset_x_data: got %h want 00", bus.x_data); else pass_cnt++;
        total_cnt++; if (err !== 2'b00) $display("FAIL reset_err: got %b want 00", err); else pass_cnt++;
        total_cnt++; if (xfer_cnt !== 16'd0) $display("FAIL reset_xfer_cnt: got %0d want 0", xfer_cnt); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++; if (bus.s_ready !== 1'b1) $display("FAIL post_reset_s_ready: got %b want 1", bus.s_ready); else pass_cnt++;
    endtask

    task automatic test_single();
        logic [DW-1:0] want;
        int n;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hA5;
        exp_q.push_back(8'hA5);
        exp_req = ~exp_req;
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total_cnt++; if (bus.x_req !== exp_req) $display("FAIL single_x_req: got %b want %b", bus.x_req, exp_req); else pass_cnt++;
        total_cnt++; if (bus.x_data !== want) $display("FAIL single_x_data: got %h want %h", bus.x_data, want); else pass_cnt++;
        total_cnt++; if (bus.s_ready !== 1'b0) $display("FAIL single_busy: got %b want 0", bus.s_ready); else pass_cnt++;
        repeat (3) @(negedge clk);
        bus.x_ack = exp_req;
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.s_ready) break;
        end
        exp_cnt++;
        total_cnt++; if (n !== SYNC + 1) $display("FAIL single_ack_latency: got %0d want %0d", n, SYNC + 1); else pass_cnt++;
        total_cnt++; if (xfer_cnt !== exp_cnt) $display("FAIL single_xfer_cnt: got %0d want %0d", xfer_cnt, exp_cnt); else pass_cnt++;
        total_cnt++; if (err !== 2'b00) $display("FAIL single_err: got %b want 00", err); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] words [3];
        logic [DW-1:0] want, last_data;
        logic          last_req;
        int            toggles, last_tog, cyc, n;
        words = '{8'h01, 8'h02, 8'h03};
        toggles = 0; last_tog = 0; cyc = 0;
        last_req  = bus.x_req;
        last_data = bus.x_data;
        bus.s_valid = 1'b1;
        bus.s_data  = words[0];
        exp_q.push_back(words[0]);
        while (toggles < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.x_req !== last_req) begin
                toggles++;
                exp_req = ~exp_req;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                total_cnt++; if (bus.x_data !== want) $display("FAIL b2b_x_data: got %h want %h", bus.x_data, want); else pass_cnt++;
                if (toggles > 1) begin
                    total_cnt++; if (cyc - last_tog !== SYNC + 2) $display("FAIL b2b_spacing: got %0d want %0d", cyc - last_tog, SYNC + 2); else pass_cnt++;
                end
                last_tog  = cyc;
                last_req  = bus.x_req;
                last_data = bus.x_data;
                bus.x_ack = bus.x_req;
                exp_cnt++;
                if (toggles < 3) begin
                    bus.s_data = words[toggles];
                    exp_q.push_back(words[toggles]);
                end else begin
                    bus.s_valid = 1'b0;
                end
            end else begin
                total_cnt++; if (bus.x_data !== last_data) $display("FAIL b2b_x_data_stable: got %h want %h", bus.x_data, last_data); else pass_cnt++;
            end
        end
        total_cnt++; if (toggles !== 3) $display("FAIL b2b_toggle_count: got %0d want 3", toggles); else pass_cnt++;
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.s_ready) break;
        end
        total_cnt++; if (bus.s_ready !== 1'b1) $display("FAIL b2b_final_ready: got %b want 1", bus.s_ready); else pass_cnt++;
        total_cnt++; if (xfer_cnt !== exp_cnt) $display("FAIL b2b_xfer_cnt: got %0d want %0d", xfer_cnt, exp_cnt); else pass_cnt++;
        total_cnt++; if (err !== 2'b00) $display("FAIL b2b_err: got %b want 00", err); else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic [DW-1:0] want;
        int n;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h3C;
        exp_q.push_back(8'h3C);
        exp_req = ~exp_req;
        @(negedge clk);
        bus.s_valid = 1'b0;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total_cnt++; if (bus.x_data !== want) $display("FAIL to_x_data: got %h want %h", bus.x_data, want); else pass_cnt++;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 10) begin
                bus.s_valid = 1'b1;
                bus.s_data  = 8'hFF;
            end
            if (k == 20) bus.s_valid = 1'b0;
            if (k == TO_CYC - 2) begin
                total_cnt++; if (err !== 2'b00) $display("FAIL to_err_early: got %b want 00", err); else pass_cnt++;
            end
            if (k == TO_CYC - 1) begin
                total_cnt++; if (err !== 2'b01) $display("FAIL to_err_set: got %b want 01", err); else pass_cnt++;
            end
        end
        total_cnt++; if (bus.x_req !== exp_req) $display("FAIL to_x_req_held: got %b want %b", bus.x_req, exp_req); else pass_cnt++;
        total_cnt++; if (bus.x_data !== 8'h3C) $display("FAIL to_x_data_held: got %h want 3c", bus.x_data); else pass_cnt++;
        total_cnt++; if (bus.s_ready !== 1'b0) $display("FAIL to_still_wait: got %b want 0", bus.s_ready); else pass_cnt++;
        bus.x_ack = exp_req;
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.s_ready) break;
        end
        exp_cnt++;
        total_cnt++; if (n !== SYNC + 1) $display("FAIL to_late_ack: got %0d want %0d", n, SYNC + 1); else pass_cnt++;
        total_cnt++; if (xfer_cnt !== exp_cnt) $display("FAIL to_xfer_cnt: got %0d want %0d", xfer_cnt, exp_cnt); else pass_cnt++;
        total_cnt++; if (err !== 2'b01) $display("FAIL to_err_sticky: got %b want 01", err); else pass_cnt++;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total_cnt++; if (err !== 2'b00) $display("FAIL to_err_clr: got %b want 00", err); else pass_cnt++;
    endtask

    task automatic test_ack_timeout_race();
        logic [DW-1:0] want;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h5A;
        exp_q.push_back(8'h5A);
        exp_req = ~exp_req;
        @(negedge clk);
        bus.s_valid = 1'b0;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total_cnt++; if (bus.x_data !== want) $display("FAIL race_x_data: got %h want %h", bus.x_data, want); else pass_cnt++;
        for (int k = 1; k <= TO_CYC - 1; k++) begin
            @(negedge clk);
            if (k == TO_CYC - 4) bus.x_ack = exp_req;
            if (k == TO_CYC - 2) begin
                total_cnt++; if (bus.s_ready !== 1'b0) $display("FAIL race_early_idle: got %b want 0", bus.s_ready); else pass_cnt++;
            end
        end
        exp_cnt++;
        total_cnt++; if (err !== 2'b00) $display("FAIL race_err: got %b want 00", err); else pass_cnt++;
        total_cnt++; if (bus.s_ready !== 1'b1) $display("FAIL race_idle: got %b want 1", bus.s_ready); else pass_cnt++;
        total_cnt++; if (xfer_cnt !== exp_cnt) $display("FAIL race_xfer_cnt: got %0d want %0d", xfer_cnt, exp_cnt); else pass_cnt++;
    endtask

    task automatic test_spurious();
        @(negedge clk);
        bus.x_ack = ~bus.x_ack;
        for (int k = 1; k <= SYNC + 1; k++) begin
            @(negedge clk);
            if (k == SYNC) begin
                total_cnt++; if (err[ERR_SPUR] !== 1'b0) $display("FAIL spur_early: got %b want 0", err[ERR_SPUR]); else pass_cnt++;
            end
        end
        total_cnt++; if (err[ERR_SPUR] !== 1'b1) $display("FAIL spur_set: got %b want 1", err[ERR_SPUR]); else pass_cnt++;
        total_cnt++; if (bus.s_ready !== 1'b1) $display("FAIL spur_state: got %b want 1", bus.s_ready); else pass_cnt++;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total_cnt++; if (err[ERR_SPUR] !== 1'b1) $display("FAIL spur_set_wins: got %b want 1", err[ERR_SPUR]); else pass_cnt++;
        bus.x_ack = ~bus.x_ack;
        repeat (SYNC + 2) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total_cnt++; if (err !== 2'b00) $display("FAIL spur_clr: got %b want 00", err); else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        logic [DW-1:0] want;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hC3;
        exp_q.push_back(8'hC3);
        exp_req = ~exp_req;
        @(negedge clk);
        bus.s_valid = 1'b0;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total_cnt++; if (bus.x_data !== want) $display("FAIL rst_wait_x_data: got %h want %h", bus.x_data, want); else pass_cnt++;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        bus.x_ack = 1'b0;
        exp_req = 1'b0;
        exp_cnt = 16'd0;
        exp_q.delete();
        #1;
        total_cnt++; if (bus.x_req !== exp_req) $display("FAIL rst_wait_x_req: got %b want %b", bus.x_req, exp_req); else pass_cnt++;
        total_cnt++; if (bus.s_ready !== 1'b1) $display("FAIL rst_wait_s_ready: got %b want 1", bus.s_ready); else pass_cnt++;
        total_cnt++; if (xfer_cnt !== exp_cnt) $display("FAIL rst_wait_xfer_cnt: got %0d want %0d", xfer_cnt, exp_cnt); else pass_cnt++;
        total_cnt++; if (err !== 2'b00) $display("FAIL rst_wait_err: got %b want 00", err); else pass_cnt++;
        total_cnt++; if (bus.x_data !== 8'h00) $display("FAIL rst_wait_x_data_clr: got %h want 00", bus.x_data); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        total_cnt++; if (xfer_cnt !== exp_cnt) $display("FAIL rst_wait_no_count: got %0d want %0d", xfer_cnt, exp_cnt); else pass_cnt++;
        total_cnt++; if (err !== 2'b00) $display("FAIL rst_wait_err_after: got %b want 00", err); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_ack_timeout_race();
        test_spurious();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/cdc_tx_ctrl.md
CDC_TX_CTRL -- requirements
Module: cdc_tx_ctrl

Interface
REQ-001 Parameter DW, default 8: width of transferred data word.
REQ-002 Parameter SYNC, default 2: number of flop stages synchronising x_ack into CP domain (min 2).
REQ-003 Parameter TO_CYC, default 256: WAIT cycles without acknowledge before timeout flag (min 4).
REQ-004 CP  input  1: source-domain clock; all state updates on rising edge.
REQ-005 CLR  input  1: asynchronous, active-low reset.
REQ-006 s_valid  input  1: upstream word valid.
REQ-007 s_ready  output  1: controller can accept a word this cycle.
REQ-008 s_data  input  DW: upstream word, sampled on accept.
REQ-009 x_req  output  1: two-phase request toggle to destination domain, registered.
REQ-010 x_data  output  DW: held crossing data, registered, stable while request outstanding.
REQ-011 x_ack  input  1: two-phase acknowledge toggle from destination domain, asynchronous to CP.
REQ-012 err  output  2: sticky flags; bit0 timeout, bit1 spurious acknowledge.
REQ-013 err_clr  input  1: clears err flags, one-cycle pulse.
REQ-014 xfer_cnt  output  16: count of completed transfers.

Function
REQ-015 FSM SHALL have two states: IDLE, WAIT.
REQ-016 s_ready SHALL equal (state == IDLE), combinational from state.
REQ-017 Accept = s_valid && s_ready; on accept edge: x_data <= s_data, x_req <= ~x_req, count <= 0, state -> WAIT.
REQ-018 ack_s = x_ack after SYNC CP flops; acknowledge detected when ack_s == x_req.
REQ-019 In WAIT, on detected acknowledge: state -> IDLE, xfer_cnt increments (wraps 0xFFFF -> 0x0000); s_ready high from next cycle.
REQ-020 Back-to-back: no accept possible in same cycle as acknowledge; minimum spacing between x_req toggles = SYNC+2 CP cycles given zero destination delay.
REQ-021 x_data SHALL change only on accept edges.
REQ-022 In WAIT without acknowledge: count increments, saturating at TO_CYC-1; at the edge where count reaches TO_CYC-1, err[0] <= 1; state stays WAIT, no retransmit, x_req unchanged.
REQ-023 Acknowledge and timeout on same edge: acknowledge wins, err[0] not set.
REQ-024 In IDLE, ack_s != x_req (unsolicited ack toggle) SHALL set err[1]; state unchanged.
REQ-025 err_clr clears both err bits; same-edge set and clear: set wins.
REQ-026 s_valid high while s_ready low SHALL have no effect; s_data ignored.

Reset
REQ-027 CLR low SHALL asynchronously force: state IDLE, x_req 0, x_data 0, err 0, count 0, xfer_cnt 0, all ack_s stages 0; so s_ready=1 during reset.
REQ-028 CLR asserted mid-WAIT SHALL abandon the outstanding transfer without incrementing xfer_cnt; destination side shares reset release so x_ack returns to 0.

Structure
REQ-029 Shared package cdc_pkg SHALL hold state enum (IDLE, WAIT) and err bit index constants (ERR_TO=0, ERR_SPUR=1).
REQ-030 Acknowledge synchroniser SHALL be a sub-module instance of the existing async_ff (DW=1, chained to SYNC stages), clocked by CP, cleared by CLR.

Verification
REQ-031 Single transfer: reset release, s_valid=1 s_data=0xA5 one cycle -> x_data=0xA5, x_req 0->1 next edge; bench toggles x_ack after 3 cycles -> s_ready high SYNC+1 edges later, xfer_cnt=1.
REQ-032 Back-to-back: s_valid held high with 0x01,0x02,0x03, bench acks immediately -> three x_req toggles, x_data stable between toggles, xfer_cnt=3, err=0.
REQ-033 Timeout: accept 0x3C, no x_ack for 300 cycles (TO_CYC=256) -> err=2'b01 at WAIT cycle 255, x_req unchanged; later ack -> IDLE, xfer_cnt=1; err_clr -> err=0.
REQ-034 Ack/timeout race: x_ack timed so ack_s matches on count TO_CYC-1 edge -> err=0, state IDLE.
REQ-035 Spurious ack: in IDLE toggle x_ack -> err[1]=1 SYNC+1 edges later; err_clr same edge as a second spurious event -> err[1] stays 1.
REQ-036 Reset mid-WAIT: CLR low during WAIT -> immediately x_req=0, s_ready=1, xfer_cnt=0, err=0, no CP edge required.
